dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//   Shares the single-port data memory between the core load/store path and a
//   host port (testbench loader / result readback). Core has priority; a
//   starvation counter forces one host grant after STARVE_MAX waiting cycles.
//   Sits between the core (alu rslt address, rf store value, op decode) and dmem.
// PARAMETERS
//   AW          8   address width (dmem depth 2**AW)
//   DW          8   data width
//   STARVE_MAX  4   host wait cycles before a forced host grant (>=1)
// PORTS
//   clk          in   1   rising-edge clock
//   reset        in   1   asynchronous, active-low reset
//   core_req     in   1   core access request (load or store), level
//   core_we      in   1   1=store, 0=load
//   core_addr    in   AW  core address
//   core_wdata   in   DW  core store data
//   core_gnt     out  1   core access performed this cycle (comb)
//   core_stall   out  1   core_req & ~core_gnt; core must hold PC and inputs
//   core_rvalid  out  1   load data valid, 1 cycle after granted load
//   core_rdata   out  DW  registered load data
//   host_req     in   1   host access request, level
//   host_we      in   1   1=write, 0=read
//   host_addr    in   AW  host address
//   host_wdata   in   DW  host write data
//   host_gnt     out  1   host access performed this cycle (comb)
//   host_rvalid  out  1   read data valid, 1 cycle after granted read
//   host_rdata   out  DW  registered read data
//   mem_we       out  1   to dmem we
//   mem_addr     out  AW  to dmem addr
//   mem_di       out  DW  to dmem di
//   mem_dout     in   DW  from dmem dout (combinational read of mem_addr)
//   starve_cnt   out  3   debug: current host wait count
// BEHAVIOUR
//   Reset (reset=0, async): starve_cnt=0, force_host=0, rvalid=0, rdata=0,
//     last_owner=CORE. Grants are comb but masked to 0 while reset=0.
//   Arbitration, evaluated every cycle (no multi-cycle hold):
//     - force_host=1 & host_req          -> host_gnt
//     - else core_req                    -> core_gnt
//     - else host_req                    -> host_gnt
//     - else none. Exactly one or zero grants per cycle; never both.
//   Mux: mem_addr/mem_di/mem_we from the granted side; no grant -> mem_we=0,
//     mem_addr/mem_di hold last granted values (no spurious writes).
//   Starvation: host_req & ~host_gnt -> starve_cnt+1 (saturate at STARVE_MAX);
//     host_gnt or ~host_req -> starve_cnt=0. force_host = (starve_cnt==STARVE_MAX),
//     registered; cleared on the cycle after the forced host grant.
//   Reads: on a granted load/read, mem_dout latched into <side>_rdata at the
//     clock edge; <side>_rvalid=1 for exactly the next cycle. Write grant ->
//     rvalid stays 0. rdata holds until the next read for that side.
//   Back-to-back: consecutive grants to either side are allowed every cycle;
//     read-after-write same address returns new data (write lands on the edge,
//     read next cycle sees it).
//   Simultaneous forced host and core store: store stalls 1 cycle, core_stall=1,
//     core must hold core_* stable; arbiter does not capture core inputs.
//   Host drop of host_req while waiting: counter clears, no grant issued.
//   Reset mid-access: pending rvalid cancelled, no write issued after reset falls.
//   Latency: write 0 cycles (same-edge commit); read 1 cycle to rvalid.
// TESTING
//   1 reset=0 with both reqs high -> both gnt=0, mem_we=0, rvalid=0, starve_cnt=0.
//   2 host only: write 0x5A @0x10, read @0x10 -> host_gnt each cycle,
//     host_rvalid=1 next cycle, host_rdata=0x5A.
//   3 core_req held 8 cycles, host_req held, STARVE_MAX=4 -> host granted on
//     cycle 6 (after 4 wait + force reg), core_stall=1 that cycle only, then core.
//   4 same-cycle core store 0x33 @0x20 and host read @0x20 -> core first; host
//     read next cycle returns 0x33.
//   5 core load @0x7F (mem=0xC1) then host write -> core_rvalid=1, core_rdata=0xC1,
//     host_rvalid=0 throughout.
//   6 assert reset=0 the cycle after a granted core load -> core_rvalid=0, no mem_we
//     until release; starve_cnt=0 after release.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: core, host and data-memory signals around the dmem arbiter
interface dmem_arbiter_if #(parameter int AW = 8, parameter int DW = 8);
  logic          core_req;
  logic          core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic          core_gnt;
  logic          core_stall;
  logic          core_rvalid;
  logic [DW-1:0] core_rdata;
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt;
  logic          host_rvalid;
  logic [DW-1:0] host_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_di;
  logic [DW-1:0] mem_dout;
  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_gnt, core_stall, core_rvalid, core_rdata,
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rvalid, host_rdata,
    output mem_we, mem_addr, mem_di,
    input  mem_dout
  );
  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_gnt, core_stall, core_rvalid, core_rdata,
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rvalid, host_rdata,
    input  mem_we, mem_addr, mem_di,
    output mem_dout
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: core-priority sharing of the data memory with a host port and starvation-forced host grants
module dmem_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            reset,
  dmem_arbiter_if.slave   bus,
  output logic [2:0]      starve_cnt
);
  localparam logic [2:0] cnt_max = 3'(STARVE_MAX);
  logic          force_host;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_di;
  logic          host_wait;
  assign bus.host_gnt   = reset & bus.host_req & (force_host | ~bus.core_req);
  assign bus.core_gnt   = reset & bus.core_req & ~(force_host & bus.host_req);
  assign bus.core_stall = bus.core_req & ~bus.core_gnt;
  assign host_wait      = bus.host_req & ~bus.host_gnt;
  // Idle cycles keep the last address/data on the bus so dmem inputs never glitch
  assign bus.mem_we   = bus.core_gnt ? bus.core_we : bus.host_gnt & bus.host_we;
  assign bus.mem_addr = bus.core_gnt ? bus.core_addr : bus.host_gnt ? bus.host_addr : last_addr;
  assign bus.mem_di   = bus.core_gnt ? bus.core_wdata : bus.host_gnt ? bus.host_wdata : last_di;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt      <= 3'd0;
      force_host      <= 1'b0;
      last_addr       <= '0;
      last_di         <= '0;
      bus.core_rvalid <= 1'b0;
      bus.core_rdata  <= '0;
      bus.host_rvalid <= 1'b0;
      bus.host_rdata  <= '0;
    end else begin
      starve_cnt      <= host_wait ? (starve_cnt == cnt_max ? cnt_max : starve_cnt + 3'd1) : 3'd0;
      force_host      <= host_wait & (starve_cnt == cnt_max);
      bus.core_rvalid <= bus.core_gnt & ~bus.core_we;
      bus.host_rvalid <= bus.host_gnt & ~bus.host_we;
      if (bus.core_gnt & ~bus.core_we) bus.core_rdata <= bus.mem_dout;
      if (bus.host_gnt & ~bus.host_we) bus.host_rdata <= bus.mem_dout;
      if (bus.core_gnt | bus.host_gnt) begin
        last_addr <= bus.mem_addr;
        last_di   <= bus.mem_di;
      end
    end
  end
endmodule
